// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - sizing helpers shared by the pipelined adder tree
package adder_tree_pkg;

    // Number of reduction levels: ceil(log2(num_in)), never less than one.
    function automatic int tree_levels(input int num_in);
        int l;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << l) < num_in) l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    // Operand count after k levels of pairwise reduction.
    function automatic int level_count(input int num_in, input int k);
        int m;
        m = num_in;
        for (int i = 0; i < k; i++) m = (m + 1) / 2;
        return m;
    endfunction

    // Full-precision width of the final sum.
    function automatic int sum_width(input int n, input int num_in);
        return n + tree_levels(num_in);
    endfunction

    // Bit offset of level k's operands inside the flat inter-level bus;
    // level j holds level_count(num_in, j) operands of n+j bits.
    function automatic int level_offset(input int n, input int num_in, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) off += level_count(num_in, j) * (n + j);
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise reduction level
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int M_IN   = 8,
    parameter int W_IN   = 16,
    parameter int SIGNED = 0,
    localparam int M_OUT = level_count(M_IN, 1),
    localparam int W_OUT = W_IN + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid_i,
    input  logic [M_IN*W_IN-1:0]   data_i,
    output logic                   valid_o,
    output logic [M_OUT*W_OUT-1:0] data_o
);

    logic [M_OUT*W_OUT-1:0] sum_d;
    logic [M_OUT*W_OUT-1:0] data_q;
    logic                   valid_q;

    for (genvar j = 0; j < M_OUT; j++) begin : g_pair
        logic [W_IN-1:0]  a_raw;
        logic [W_OUT-1:0] a_ext;

        assign a_raw = data_i[2*j*W_IN +: W_IN];
        assign a_ext = (SIGNED != 0) ? {a_raw[W_IN-1], a_raw} : {1'b0, a_raw};

        if (2*j + 1 < M_IN) begin : g_add
            logic [W_IN-1:0]  b_raw;
            logic [W_OUT-1:0] b_ext;

            assign b_raw = data_i[(2*j+1)*W_IN +: W_IN];
            assign b_ext = (SIGNED != 0) ? {b_raw[W_IN-1], b_raw} : {1'b0, b_raw};

            n_bit_adder #(
                .N (W_OUT)
            ) u_add (
                .a_i   (a_ext),
                .b_i   (b_ext),
                .sum_o (sum_d[j*W_OUT +: W_OUT])
            );
        end else begin : g_pass
            // Odd leftover operand: widen and forward untouched.
            assign sum_d[j*W_OUT +: W_OUT] = a_ext;
        end
    end

    // Level register: data loads on every enabled cycle, valid tracks the bubble pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/n_bit_adder.sv
// rtl/n_bit_adder.sv - plain N-bit two-operand adder
module n_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    // Callers pre-extend operands, so the carry out is never needed.
    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - fully pipelined multi-operand adder with valid/ready
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int N      = 16,
    parameter int NUM_IN = 8,
    parameter int SIGNED = 0,
    localparam int L     = tree_levels(NUM_IN),
    localparam int SW    = sum_width(N, NUM_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_IN*N-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SW-1:0]       out_sum
);

    localparam int BUS_W = level_offset(N, NUM_IN, L + 1);

    // Flat bus holding every level's operands back to back; slice 0 is the input vector.
    logic [BUS_W-1:0] bus;
    logic [L:0]       vld;
    logic             en;

    // Whole pipeline advances together unless the output is full and blocked.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    assign bus[level_offset(N, NUM_IN, 0) +: NUM_IN*N] = in_data;
    assign vld[0] = in_valid;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int M_IN    = level_count(NUM_IN, k - 1);
        localparam int M_OUT   = level_count(NUM_IN, k);
        localparam int W_IN    = N + k - 1;
        localparam int OFF_IN  = level_offset(N, NUM_IN, k - 1);
        localparam int OFF_OUT = level_offset(N, NUM_IN, k);

        adder_tree_level #(
            .M_IN   (M_IN),
            .W_IN   (W_IN),
            .SIGNED (SIGNED)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (vld[k-1]),
            .data_i  (bus[OFF_IN +: M_IN*W_IN]),
            .valid_o (vld[k]),
            .data_o  (bus[OFF_OUT +: M_OUT*(W_IN+1)])
        );
    end

    // The last level register doubles as the output register.
    assign out_valid = vld[L];
    assign out_sum   = bus[level_offset(N, NUM_IN, L) +: SW];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb/tb_pipelined_adder_tree.sv - scoreboard bench for pipelined_adder_tree
module tb_pipelined_adder_tree;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // 8 unsigned operands
    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [127:0] a_in_data = '0;
    logic [18:0]  a_out_sum;
    // 8 signed operands
    logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [127:0] s_in_data = '0;
    logic [18:0]  s_out_sum;
    // 5 unsigned operands
    logic         f_in_valid = 1'b0, f_in_ready, f_out_valid, f_out_ready = 1'b1;
    logic [79:0]  f_in_data = '0;
    logic [18:0]  f_out_sum;

    logic [18:0] q_a[$];
    logic [18:0] q_s[$];
    logic [18:0] q_f[$];
    int          a_pop_cyc[$];

    pipelined_adder_tree #(.N(16), .NUM_IN(8), .SIGNED(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum));

    pipelined_adder_tree #(.N(16), .NUM_IN(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum));

    pipelined_adder_tree #(.N(16), .NUM_IN(5), .SIGNED(0)) u_dut_f (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_sum(f_out_sum));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fill(input int base, input int step, input int cnt);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < cnt; i++) v[i*16 +: 16] = 16'(base + i*step);
        return v;
    endfunction

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_unexpected actual=%0d required=none", a_out_sum);
                end else begin
                    checks--;
                    check("a_sum", 32'(a_out_sum), 32'(q_a.pop_front()));
                    a_pop_cyc.push_back(cyc);
                end
            end
            if (s_out_valid && s_out_ready) begin
                checks++;
                if (q_s.size() == 0) begin
                    failures++;
                    $display("FAIL s_unexpected actual=%0d required=none", s_out_sum);
                end else begin
                    checks--;
                    check("s_sum", 32'(s_out_sum), 32'(q_s.pop_front()));
                end
            end
            if (f_out_valid && f_out_ready) begin
                checks++;
                if (q_f.size() == 0) begin
                    failures++;
                    $display("FAIL f_unexpected actual=%0d required=none", f_out_sum);
                end else begin
                    checks--;
                    check("f_sum", 32'(f_out_sum), 32'(q_f.pop_front()));
                end
            end
        end
    end

    // Present one vector (call at posedge+1), wait for acceptance, push the expectation.
    task automatic send(input int which, input logic [127:0] d, input logic [18:0] exp, output int waits);
        logic rdy;
        rdy   = 1'b0;
        waits = 0;
        case (which)
            0: begin a_in_data = d; a_in_valid = 1'b1; end
            1: begin s_in_data = d; s_in_valid = 1'b1; end
            default: begin f_in_data = d[79:0]; f_in_valid = 1'b1; end
        endcase
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            rdy = (which == 0) ? a_in_ready : (which == 1) ? s_in_ready : f_in_ready;
            if (rdy) break;
            waits++;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=0 required=1");
        end
        @(posedge clk);
        if (rdy) begin
            case (which)
                0: q_a.push_back(exp);
                1: q_s.push_back(exp);
                default: q_f.push_back(exp);
            endcase
        end
        #1;
        a_in_valid = 1'b0;
        s_in_valid = 1'b0;
        f_in_valid = 1'b0;
    endtask

    // Wait until every expected result has emerged; returns at posedge+1.
    task automatic drain();
        for (int t = 0; t < 64; t++) begin
            if (q_a.size() == 0 && q_s.size() == 0 && q_f.size() == 0) break;
            @(negedge clk);
        end
        check("drain_left", 32'(q_a.size() + q_s.size() + q_f.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int c0;
        int lat;
        int seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_valid", 32'(a_out_valid), 0);
        check("rst_a_sum",   32'(a_out_sum),   0);
        check("rst_a_ready", 32'(a_in_ready),  1);
        check("rst_s_valid", 32'(s_out_valid), 0);
        check("rst_f_valid", 32'(f_out_valid), 0);
        @(posedge clk);
        #1;

        // 1: single vector of ones, latency of 3 and a one-cycle pulse
        c0 = cyc;
        send(0, fill(1, 0, 8), 19'd8, w);
        lat = -1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (a_out_valid) begin
                lat = cyc - c0;
                break;
            end
        end
        check("t1_latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("t1_valid_drop", 32'(a_out_valid), 0);
        drain();

        // 2: boundary values
        send(0, fill(65535, 0, 8), 19'h7FFF8, w);
        send(1, fill(32768, 0, 8), 19'h40000, w);
        send(1, {4{16'h8000, 16'h7FFF}}, 19'h7FFFC, w);
        drain();

        // 3: back-to-back stream, outputs on consecutive cycles
        a_pop_cyc.delete();
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            send(0, fill(k, 1, 8), 19'(28 + 8*k), w);
            seen += w;
        end
        check("t3_in_ready_waits", 32'(seen), 0);
        drain();
        check("t3_pop_count", 32'(a_pop_cyc.size()), 4);
        for (int i = 1; i < a_pop_cyc.size(); i++)
            check("t3_consecutive", 32'(a_pop_cyc[i] - a_pop_cyc[i-1]), 1);

        // 4: backpressure once the first result is valid
        a_pop_cyc.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, fill(k, 1, 8), 19'(28 + 8*k), w);
            end
            begin
                seen = 0;
                for (int t = 0; t < 20; t++) begin
                    @(posedge clk);
                    #1;
                    if (a_out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                check("t4_first_valid", 32'(seen), 1);
                a_out_ready = 1'b0;
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    check("t4_stall_in_ready", 32'(a_in_ready), 0);
                    check("t4_stall_valid", 32'(a_out_valid), 1);
                    check("t4_stall_sum", 32'(a_out_sum), 28);
                end
                @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain();
        check("t4_pop_count", 32'(a_pop_cyc.size()), 4);

        // 5: reset while two vectors are inside the tree
        send(0, fill(65535, 0, 8), 19'h7FFF8, w);
        send(0, fill(1, 0, 8), 19'd8, w);
        rst = 1'b1;
        q_a.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after_rst", 32'(a_out_valid), 0);
        check("t5_sum_after_rst", 32'(a_out_sum), 0);
        seen = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("t5_no_ghost", 32'(seen), 0);
        @(posedge clk);
        #1;
        send(0, fill(2, 0, 8), 19'd16, w);
        drain();

        // 6: five operands, non-power-of-two tree
        send(2, fill(1, 1, 5), 19'd15, w);
        send(2, fill(65535, 0, 5), 19'd327675, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Parametrised, fully pipelined multi-operand adder.
- Reduces NUM_IN operands of N bits each to one full-precision sum, with one register level per tree level.
- Valid/ready handshake on input and output; accepts one operand vector per cycle.
- Feeds accumulators and dot-product datapaths in the ADDER_TREE area.

Parameters:
- N, 16, width of each input operand.
- NUM_IN, 8, number of operands; legal range 2..64; need not be a power of two.
- SIGNED, 0, 0 = operands unsigned (zero-extend); 1 = two's complement (sign-extend).
- Derived, not overridable: L = clog2(NUM_IN) levels; SW = N+L sum width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand vector valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  NUM_IN*N  packed operands; operand i = in_data[i*N +: N]
- out_valid  output  1  out_sum holds a valid result
- out_ready  input  1  downstream accepts the result
- out_sum  output  SW  sum of all operands, full precision

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits and all stage data registers clear to 0;
  - out_valid=0 and out_sum=0 from the next cycle.
  - Applies mid-operation: in-flight vectors are discarded and never emerge.
- Global advance enable: en = out_ready | ~out_valid, evaluated combinationally.
  - in_ready = en, with a combinational path from out_ready.
- Accept: when in_valid & in_ready, the vector enters level 1 at that edge.
- When en=0:
  - every level, including the output register, holds its data and valid bits;
  - in_data is ignored.
- Latency: exactly L cycles from accept edge to out_valid=1 when no stall; each stall cycle adds 1.
- Throughput: 1 vector per cycle while out_ready=1. Bubbles propagate as valid=0 stages and are not compressed.
- Level k (1..L):
  - takes M(k-1) operands of width N+k-1 and produces M(k) = ceil(M(k-1)/2) operands of width N+k;
  - M(0) = NUM_IN;
  - each pair is extended by 1 bit per SIGNED, then added;
  - an odd leftover operand is extended and passed through unchanged.
- Non-power-of-two NUM_IN: missing lanes behave as zero; latency is still L.
- No overflow is possible:
  - unsigned: 0 <= sum <= NUM_IN*(2^N-1);
  - signed: the result is the exact two's-complement value in SW bits.
- Stage data registers load whenever en=1, regardless of valid. out_sum is checked only when out_valid=1, except the reset value of 0.
- Output holds stable (out_valid, out_sum unchanged) while out_valid=1 & out_ready=0.
- Simultaneous events: rst has priority over accept and advance. Acceptance and output handoff in the same cycle are allowed.

Decomposition:
- Package adder_tree_pkg:
  - function tree_levels(num_in), returning clog2 with minimum 1;
  - function level_count(num_in, k), returning M(k);
  - function sum_width(n, num_in).
- Sub-module adder_tree_level:
  - one registered reduction level;
  - parameters M_IN, W_IN, SIGNED;
  - inputs: clk, rst, en, valid in, packed operands;
  - outputs: registered valid, packed M_OUT results of W_IN+1 bits;
  - each pair sum uses the existing n_bit_adder with N = W_IN+1 on the extended operands.
- Top module: generate loop over L instances of adder_tree_level, plus the handshake logic.

Test Plan (N=16, NUM_IN=8, SIGNED=0, SW=19 unless stated):
1. Reset, then one vector with all operands 1 and out_ready=1 -> out_valid rises exactly 3 cycles after the accept edge, out_sum=19'd8; out_valid=0 on the following cycle.
2. Boundary values:
   - all operands 16'hFFFF -> out_sum=19'h7FFF8 (524280);
   - SIGNED=1 with all operands 16'h8000 -> out_sum=19'h40000 (-262144);
   - SIGNED=1 with operands alternating 16'h7FFF / 16'h8000 -> out_sum=19'h7FFFC (-4).
3. Streaming: 4 back-to-back vectors where operand i = i+k for k=0..3, out_ready=1 -> sums 28, 36, 44, 52 on 4 consecutive cycles starting 3 cycles after the first accept; in_ready held at 1 throughout.
4. Backpressure: same stream with out_ready=0 for 5 cycles once the first result is valid -> in_ready=0 and out_sum held at 28 during the stall; after release, the exact sequence 28, 36, 44, 52 with no loss or duplication.
5. Reset mid-flight: rst=1 for 1 cycle while 2 vectors are in levels 1-2 -> out_valid=0 and out_sum=0 the next cycle; no result emerges within the following 5 cycles; a new vector of all 2s yields 16 after 3 cycles.
6. NUM_IN=5, L=3, SW=19: operands 1,2,3,4,5 -> out_sum=15 after 3 cycles; operands all 16'hFFFF -> 327675.
